// File: rtl/vga_timing_pkg.sv
// Shared widths, 640x480@60 timing defaults and total-period helpers
// for the VGA raster timing controller.
package vga_timing_pkg;

  localparam int CW = 11;
  localparam int RW = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_t;

  function automatic int h_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset value.
// DEPTH must be at least 1; callers bypass it for zero latency.
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator and pin driver.
// Optional macro VGA_BORDER_EN forces a white frame on edge pixels.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int PIX_LATENCY = 1,
  parameter int SYNC_POL    = 0
) (
  input  logic          iVGA_CLK,
  input  logic          iRST,
  input  logic [RW-1:0] iRed,
  input  logic [RW-1:0] iGreen,
  input  logic [RW-1:0] iBlue,
  output logic [CW-1:0] oVGA_X,
  output logic [CW-1:0] oVGA_Y,
  output logic          oRequest,
  output logic          oFrameStart,
  output logic [RW-1:0] oVGA_R,
  output logic [RW-1:0] oVGA_G,
  output logic [RW-1:0] oVGA_B,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oVGA_BLANK_n,
  output logic          oVGA_SYNC_n
);

  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SP     = (SYNC_POL != 0);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  sync_t         s0;
  sync_t         sd;
  logic          edge_px;
  logic [RW-1:0] r_q, g_q, b_q;
  logic          hs_q, vs_q, blank_q;

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    s0.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s0.hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    s0.vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  assign oRequest    = s0.active;
  assign oVGA_X      = s0.active ? h_cnt : '0;
  assign oVGA_Y      = s0.active ? v_cnt : '0;
  assign oFrameStart = (h_cnt == '0) && (v_cnt == '0);

  // Sync/active travel alongside the source pipeline
  if (PIX_LATENCY == 0) begin : g_sync_bypass
    assign sd = s0;
  end else begin : g_sync_dly
    vga_delay_line #(
      .DEPTH   (PIX_LATENCY),
      .WIDTH   ($bits(sync_t)),
      .RST_VAL ('0)
    ) u_sync_dly (
      .clk (iVGA_CLK),
      .rst (iRST),
      .d   (s0),
      .q   (sd)
    );
  end

`ifdef VGA_BORDER_EN
  logic [2*CW-1:0] c0;
  logic [2*CW-1:0] cd;
  logic [CW-1:0]   hd, vd;

  assign c0 = {h_cnt, v_cnt};

  if (PIX_LATENCY == 0) begin : g_crd_bypass
    assign cd = c0;
  end else begin : g_crd_dly
    vga_delay_line #(
      .DEPTH   (PIX_LATENCY),
      .WIDTH   (2*CW),
      .RST_VAL ('0)
    ) u_crd_dly (
      .clk (iVGA_CLK),
      .rst (iRST),
      .d   (c0),
      .q   (cd)
    );
  end

  assign hd = cd[2*CW-1:CW];
  assign vd = cd[CW-1:0];
  assign edge_px = (hd == '0) || (hd == H_ACT - 1'b1) ||
                   (vd == '0) || (vd == V_ACT - 1'b1);
`else
  assign edge_px = 1'b0;
`endif

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      blank_q <= 1'b0;
      hs_q    <= ~SP;
      vs_q    <= ~SP;
    end else begin
      blank_q <= sd.active;
      hs_q    <= sd.hs ? SP : ~SP;
      vs_q    <= sd.vs ? SP : ~SP;
      if (!sd.active) begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end else if (edge_px) begin
        r_q <= '1;
        g_q <= '1;
        b_q <= '1;
      end else begin
        r_q <= iRed;
        g_q <= iGreen;
        b_q <= iBlue;
      end
    end
  end

  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_n = blank_q;
  assign oVGA_SYNC_n  = 1'b0;

endmodule
